multi_edgechk: RTL and testbench

MULTI_EDGECHK -- requirements
Module: multi_edgechk

---
 rtl/multi_edgechk.sv | 131 +++++++++++++
 tb/tb_multi_edgechk.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edgechk.sv
// Multi-channel edge checker: synchronise, debounce, qualify edges per channel, sticky flags, registered irq.
// Optional per-channel saturating event counter enabled by macro MULTI_EDGECHK_CNT_EN.
module multi_edgechk #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CH-1:0]     sig_in,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     clr,
  input  logic              irq_en,
  output logic [CH-1:0]     level_out,
  output logic [CH-1:0]     pulse_out,
  output logic [CH-1:0]     flag_out,
  output logic              irq
`ifdef MULTI_EDGECHK_CNT_EN
  ,
  output logic [8*CH-1:0]   evt_cnt
`endif
);

  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
  logic [CH-1:0][7:0]             cnt_q, cnt_d;
  logic [CH-1:0]                  level_q, level_d;
  logic [CH-1:0]                  pulse_q, pulse_d;
  logic [CH-1:0]                  flag_q, flag_d;
  logic                           irq_q, irq_d;
  logic [CH-1:0]                  sync_s;
  logic [CH-1:0]                  accept_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain, one column per channel.
  always_comb begin
    sync_d[0] = sig_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Debounce counters, level acceptance, edge qualification and sticky flags.
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    pulse_d  = '0;
    accept_s = '0;
    flag_d   = flag_q;
    for (int i = 0; i < CH; i++) begin
      if (sync_s[i] == level_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == DEB_MAX) begin
        cnt_d[i]    = 8'd0;
        level_d[i]  = sync_s[i];
        accept_s[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
      case (mode[2*i +: 2])
        2'b01:   pulse_d[i] = accept_s[i] & sync_s[i];
        2'b10:   pulse_d[i] = accept_s[i] & ~sync_s[i];
        2'b11:   pulse_d[i] = accept_s[i];
        default: pulse_d[i] = 1'b0;
      endcase
      // A new pulse overrides a coincident clear.
      flag_d[i] = pulse_d[i] | (flag_q[i] & ~clr[i]);
    end
  end

  // Interrupt follows the registered flags one cycle later.
  always_comb begin
    irq_d = irq_en & (|flag_q);
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;
  assign flag_out  = flag_q;
  assign irq       = irq_q;

`ifdef MULTI_EDGECHK_CNT_EN
  logic [CH-1:0][7:0] evt_q, evt_d;

  // Saturating per-channel pulse count; clear with a coincident pulse lands on 1.
  always_comb begin
    evt_d = evt_q;
    for (int i = 0; i < CH; i++) begin
      if (clr[i]) begin
        evt_d[i] = {7'd0, pulse_d[i]};
      end else if (pulse_d[i] && (evt_q[i] != 8'hFF)) begin
        evt_d[i] = evt_q[i] + 8'd1;
      end else begin
        evt_d[i] = evt_q[i];
      end
    end
  end

  // Event counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_cnt = evt_q;
`endif

endmodule

// File: tb/tb_multi_edgechk.sv
// Self-checking bench for multi_edgechk: directed scenarios plus randomized traffic against a sample-history model.
module tb_multi_edgechk;
  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int DEB = 4;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic [CH-1:0]   sig_in;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic            irq_en;
  logic [CH-1:0]   level_out, pulse_out, flag_out;
  logic            irq;
`ifdef MULTI_EDGECHK_CNT_EN
  logic [8*CH-1:0] evt_cnt;
`endif

  multi_edgechk #(.CH(CH), .SYNC_STAGES(SS), .DEB_CYCLES(DEB)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sig_in    (sig_in),
    .mode      (mode),
    .clr       (clr),
    .irq_en    (irq_en),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .flag_out  (flag_out),
    .irq       (irq)
`ifdef MULTI_EDGECHK_CNT_EN
    ,
    .evt_cnt   (evt_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: history of sig_in as sampled at each clock edge since reset.
  logic [CH-1:0] samp_q[$];
  logic [CH-1:0] m_lvl, m_pulse, m_flag;
  logic          m_irq;
  int            m_evt[CH];
  int            pcnt[CH];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    m_lvl   = '0;
    m_pulse = '0;
    m_flag  = '0;
    m_irq   = 1'b0;
    for (int i = 0; i < CH; i++) m_evt[i] = 0;
  endtask

  // A level flips once the last DEB synchronised samples all disagree with it;
  // the synchronised sample seen at edge n is sig_in as sampled at edge n-SS.
  task automatic model_step();
    logic [CH-1:0] nl, np, nf, smp;
    logic          ni;
    bit            all_diff, rise, fall;
    samp_q.push_front(sig_in);
    if (samp_q.size() > SS + DEB + 1) void'(samp_q.pop_back());
    for (int i = 0; i < CH; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        smp = '0;
        if (SS + j < samp_q.size()) smp = samp_q[SS + j];
        if (smp[i] == m_lvl[i]) all_diff = 1'b0;
      end
      rise  = all_diff && !m_lvl[i];
      fall  = all_diff && m_lvl[i];
      nl[i] = all_diff ? ~m_lvl[i] : m_lvl[i];
      np[i] = (mode[2*i] && rise) || (mode[2*i+1] && fall);
      nf[i] = np[i] | (m_flag[i] & ~clr[i]);
      if (clr[i]) m_evt[i] = np[i] ? 1 : 0;
      else if (np[i] && m_evt[i] < 255) m_evt[i] = m_evt[i] + 1;
    end
    ni      = irq_en & (|m_flag);
    m_lvl   = nl;
    m_pulse = np;
    m_flag  = nf;
    m_irq   = ni;
  endtask

  task automatic compare_all();
`ifdef MULTI_EDGECHK_CNT_EN
    logic [8*CH-1:0] e;
`endif
    check_val("level", level_out, m_lvl);
    check_val("pulse", pulse_out, m_pulse);
    check_val("flag", flag_out, m_flag);
    check_val("irq", irq, m_irq);
`ifdef MULTI_EDGECHK_CNT_EN
    for (int i = 0; i < CH; i++) e[8*i +: 8] = 8'(m_evt[i]);
    check_val("evt_cnt", evt_cnt, e);
`endif
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    model_step();
    compare_all();
    for (int i = 0; i < CH; i++) if (pulse_out[i]) pcnt[i]++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_pcnt();
    for (int i = 0; i < CH; i++) pcnt[i] = 0;
  endtask

  // Asynchronous reset between edges; outputs must drop without a clock edge.
  task automatic do_reset(input int hold);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_val("rst_level", level_out, 0);
    check_val("rst_pulse", pulse_out, 0);
    check_val("rst_flag", flag_out, 0);
    check_val("rst_irq", irq, 0);
`ifdef MULTI_EDGECHK_CNT_EN
    check_val("rst_evt", evt_cnt, 0);
`endif
    model_reset();
    repeat (hold) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  logic [CH-1:0] tgt;

  initial begin
    sys_rst_n = 1'b0;
    sig_in    = '0;
    mode      = '0;
    clr       = '0;
    irq_en    = 1'b0;
    clear_pcnt();
    do_reset(2);

    // Rising step on ch0: pulse at edge SS+DEB, irq one edge later.
    mode   = 8'b00_00_00_01;
    irq_en = 1'b1;
    sig_in = 4'b0001;
    for (int e = 1; e <= SS + DEB + 1; e++) begin
      tick();
      if (e == SS + DEB - 1) check_val("pre_pulse0", pulse_out[0], 0);
      if (e == SS + DEB) begin
        check_val("pulse0_edge6", pulse_out[0], 1);
        check_val("level0_edge6", level_out[0], 1);
        check_val("flag0_edge6", flag_out[0], 1);
        check_val("irq_not_yet", irq, 0);
      end
      if (e == SS + DEB + 1) begin
        check_val("irq_next", irq, 1);
        check_val("pulse0_one_cycle", pulse_out[0], 0);
      end
    end

    // Clear alone: flag drops next edge, irq the edge after.
    clr = 4'b0001;
    tick();
    check_val("clr_flag0", flag_out[0], 0);
    check_val("clr_irq_lag", irq, 1);
    clr = 4'b0000;
    tick();
    check_val("clr_irq0", irq, 0);

    // Clear coinciding with a new pulse: set wins.
    mode   = 8'b00_00_00_11;
    sig_in = 4'b0000;
    ticks(SS + DEB + 2);
    clr    = 4'b0001;
    tick();
    clr    = 4'b0000;
    sig_in = 4'b0001;
    ticks(SS + DEB - 1);
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    check_val("set_vs_clr_pulse", pulse_out[0], 1);
    check_val("set_vs_clr_flag", flag_out[0], 1);

    // Glitch rejection on ch1: 3 cycles rejected, 4 cycles accepted.
    mode   = 8'b00_00_11_11;
    sig_in = 4'b0011;
    ticks(3);
    sig_in = 4'b0001;
    ticks(10);
    check_val("glitch_level1", level_out[1], 0);
    check_val("glitch_flag1", flag_out[1], 0);
    sig_in = 4'b0011;
    ticks(4);
    sig_in = 4'b0001;
    ticks(2);
    check_val("wide_pulse1", pulse_out[1], 1);
    check_val("wide_level1", level_out[1], 1);
    ticks(10);

    // Mode 10, 11, 00 on ch2 over a rise and a fall.
    mode = 8'b00_10_00_00;
    clear_pcnt();
    sig_in[2] = 1'b1; ticks(10);
    sig_in[2] = 1'b0; ticks(10);
    check_val("mode10_pulses", pcnt[2], 1);
    mode = 8'b00_11_00_00;
    clear_pcnt();
    sig_in[2] = 1'b1; ticks(10);
    sig_in[2] = 1'b0; ticks(10);
    check_val("mode11_pulses", pcnt[2], 2);
    mode = 8'b00_00_00_00;
    clear_pcnt();
    sig_in[2] = 1'b1; ticks(10);
    check_val("mode00_level", level_out[2], 1);
    sig_in[2] = 1'b0; ticks(10);
    check_val("mode00_pulses", pcnt[2], 0);

    // All channels high at reset release pulse together.
    mode   = 8'hFF;
    sig_in = 4'hF;
    do_reset(2);
    ticks(SS + DEB - 1);
    check_val("all_pre", pulse_out, 0);
    tick();
    check_val("all_pulse", pulse_out, 4'hF);

    // Reset mid-debounce discards the pending transition.
    sig_in = 4'h0;
    ticks(12);
    sig_in = 4'hF;
    ticks(SS + 2);
    do_reset(1);
    sig_in = 4'h0;
    clear_pcnt();
    ticks(12);
    for (int i = 0; i < CH; i++) check_val("no_pulse_after_rst", pcnt[i], 0);

    // Randomized traffic with glitches, mode/irq_en changes, clears and occasional resets.
    tgt = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 15) == 0) tgt[i] = ~tgt[i];
        sig_in[i] = tgt[i] ^ ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 63) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 31) == 0) irq_en = ~irq_en;
      clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      tick();
      if ($urandom_range(0, 999) == 0) do_reset(1);
    end
    clr = 4'h0;

`ifdef MULTI_EDGECHK_CNT_EN
    // 300 qualified events on ch3 saturate the counter; clear returns it to zero.
    mode = 8'b11_00_00_00;
    for (int k = 0; k < 300; k++) begin
      sig_in[3] = ~sig_in[3];
      ticks(SS + DEB);
    end
    ticks(2);
    check_val("evt3_sat", evt_cnt[31:24], 8'd255);
    clr = 4'b1000;
    tick();
    clr = 4'b0000;
    check_val("evt3_clr", evt_cnt[31:24], 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
